// File: rtl/bram_req_master_if.sv
// Core-side req/gnt/rvalid memory bus and single-port BRAM port bundles
// used by bram_req_master.
interface bram_req_master_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic                  req;
    logic                  gnt;
    logic [31:0]           addr;
    logic                  we;
    logic [BE_W-1:0]       be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

interface bram_port_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output en, addr, we, wdata, input rdata);
    modport slave  (input en, addr, we, wdata, output rdata);
endinterface

// File: rtl/bram_req_master.sv
// Bridges the core req/gnt/rvalid protocol onto a whole-word-strobe BRAM,
// using a read-modify-write for partial-byte writes.
module bram_req_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    bram_req_master_if.slave        core,
    bram_port_if.master             bram
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int OFF  = $clog2(BE_W);

    typedef enum logic {IDLE, MERGE} state_e;

    state_e                  state_q, state_d;
    logic                    rvalid_q, rvalid_d;
    logic                    rd_resp_q, rd_resp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]         be_q, be_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic [ADDR_WIDTH-1:0]   req_word_addr;
    logic                    be_full;
    logic                    be_empty;
    logic                    partial_wr;
    logic [DATA_WIDTH-1:0]   merged_data;

    assign req_word_addr = core.addr[OFF+ADDR_WIDTH-1:OFF];
    assign be_full       = &core.be;
    assign be_empty      = ~|core.be;
    assign partial_wr    = core.we && !be_full && !be_empty;

    // Captured write bytes overlay the word read back in the previous cycle.
    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_merge
            assign merged_data[gi*8 +: 8] = be_q[gi] ? wdata_q[gi*8 +: 8]
                                                     : bram.rdata[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rvalid_q  <= 1'b0;
            rd_resp_q <= 1'b0;
            rdata_q   <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rvalid_q  <= rvalid_d;
            rd_resp_q <= rd_resp_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (core.req && partial_wr) state_d = MERGE;
            MERGE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core.gnt   = 1'b0;
        bram.en    = 1'b0;
        bram.we    = 1'b0;
        bram.addr  = req_word_addr;
        bram.wdata = core.wdata;
        rvalid_d   = 1'b0;
        rd_resp_d  = 1'b0;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        // Latch read data on the response cycle so it holds until the next read.
        rdata_d    = (rvalid_q && rd_resp_q) ? bram.rdata : rdata_q;

        case (state_q)
            IDLE: begin
                core.gnt = core.req;
                if (core.req) begin
                    bram.en   = !(core.we && be_empty);
                    bram.we   = core.we && be_full;
                    rvalid_d  = !partial_wr;
                    rd_resp_d = !core.we;
                    if (partial_wr) begin
                        addr_d  = req_word_addr;
                        be_d    = core.be;
                        wdata_d = core.wdata;
                    end
                end
            end
            MERGE: begin
                bram.en    = 1'b1;
                bram.we    = 1'b1;
                bram.addr  = addr_q;
                bram.wdata = merged_data;
                rvalid_d   = 1'b1;
            end
            default: ;
        endcase

        // Nothing reaches the BRAM while reset is held, so an interrupted RMW never writes.
        if (!rst_ni) begin
            core.gnt = 1'b0;
            bram.en  = 1'b0;
            bram.we  = 1'b0;
        end
    end

    assign core.rvalid = rvalid_q;
    assign core.rdata  = (rvalid_q && rd_resp_q) ? bram.rdata : rdata_q;

endmodule
